// File: rtl/core_pkg.sv
// core_pkg: definitions shared by fetch, the prefetch queue and decode.
//   XLEN       : pc and instruction width
//   NOP_INSTR  : canonical NOP (addi x0,x0,0); decode uses the same constant
//   fq_entry_t : one fetched {pc, instruction} pair
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage : core_pkg

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: DEPTH x WIDTH register array backing the prefetch queue.
// Synchronous write, asynchronous (combinational) read, no reset.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module fetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; the control logic never
  // presents an entry that was not written since the last reset or flush.
  // NOTE: sequential state is always assigned with <= so every reader in the
  // same edge sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fetch_queue_ram

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between fetch and decode.
// Buffers up to DEPTH {pc, instr} pairs, presents the oldest with
// first-word-fall-through, stalls fetch when full, and drops everything
// in one cycle on a taken branch/jump (flush).
//   clk, reset          : rising-edge clock, async active-low reset
//   in_valid/in_pc/in_instr, in_ready : push side from fetch
//   stall               : !in_ready, drives fetch stall
//   out_valid/out_pc/out_instr, out_ready : pop side to decode
//   flush               : taken redirect, discards all entries
//   count               : occupied entries, 0..DEPTH
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = core_pkg::XLEN,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_instr,
  output logic             in_ready,
  output logic             stall,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  NOP        = XLEN'(NOP_INSTR);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] head;

  // Both flags depend only on registered count (plus flush for out_valid),
  // so there is no combinational path from fetch back into fetch.
  assign in_ready  = (count_q != FULL_COUNT);
  assign stall     = ~in_ready;
  assign out_valid = (count_q != '0) & ~flush;
  assign count     = count_q;

  // Flush discards any same-cycle push; pop is already gated through out_valid.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Pointers are power-of-two wide, so +1 wraps modulo DEPTH for free.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP;
    if (out_valid) begin
      out_pc    = head[2*XLEN-1:XLEN];
      out_instr = head[XLEN-1:0];
    end
  end

endmodule : fetch_queue
